// File: rtl/bcd_scan_ctrl_pkg.sv
// Shared definitions for the BCD display scan controller.
//   scan_state_t : scan FSM encoding (IDLE=0, SHOW=1, BLANK=2)
//   BCD_W        : width of one packed BCD digit
//   DEC_W        : width of the decoded one-hot numeral (cathode bus)
//   bcd_invalid  : true for nibble codes 10..15
package bcd_scan_ctrl_pkg;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHOW  = 2'd1,
      S_BLANK = 2'd2
   } scan_state_t;

   localparam int BCD_W = 4;
   localparam int DEC_W = 10;

   function automatic logic bcd_invalid(input logic [BCD_W-1:0] d);
      return (d > 4'd9);
   endfunction

endpackage

// File: rtl/bcd_dec10.sv
// Combinational 4-to-10 BCD decoder, shared by all display digits.
//   in  : BCD nibble
//   out : one-hot numeral (bit n set for digit n), all zero for codes 10..15
//   err : high for codes 10..15
module bcd_dec10
   import bcd_scan_ctrl_pkg::*;
(
   input  logic [BCD_W-1:0] in,
   output logic [DEC_W-1:0] out,
   output logic             err
);

   always_comb begin
      out = '0;
      err = 1'b0;
      if (bcd_invalid(in)) begin
         err = 1'b1;
      end else begin
         out = DEC_W'(1) << in;
      end
   end

endmodule

// File: rtl/bcd_scan_ctrl.sv
// Time-multiplexed scan controller for a multi-digit decimal display.
// Cycles through DIGITS packed BCD digits: each digit is lit for DWELL
// cycles, followed by BLANK cycles with everything off. Writes land in a
// shadow buffer and reach the display buffer only at a frame wrap (or at
// once while idle), so a frame never mixes old and new digits.
//
// Ports:
//   clk, rst    : clock (rising edge), asynchronous active-high reset
//   enable      : scan enable; low forces IDLE on the next edge
//   wr_valid    : write request
//   wr_ready    : shadow buffer empty
//   wr_data     : packed BCD, digit i at [4i+3:4i]
//   anode       : one-hot digit select (registered)
//   cathode     : one-hot decoded numeral (registered)
//   digit_idx   : current digit index (registered)
//   bad_digit   : per-digit flag, display-buffer digit > 9
//   frame_done  : one-cycle pulse on the edge where the index wraps to 0
//   state       : current scan FSM state, for observation
//
// Handshake: a write transfers on any rising edge where wr_valid and
// wr_ready are both high; wr_data is captured then. wr_ready is low while
// the shadow buffer holds a value not yet copied to the display buffer.
module bcd_scan_ctrl
   import bcd_scan_ctrl_pkg::*;
#(
   parameter int DIGITS = 4,
   parameter int DWELL  = 1000,
   parameter int BLANK  = 50,
   parameter int CW     = 16
)(
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       enable,
   input  logic                       wr_valid,
   output logic                       wr_ready,
   input  logic [BCD_W*DIGITS-1:0]    wr_data,
   output logic [DIGITS-1:0]          anode,
   output logic [DEC_W-1:0]           cathode,
   output logic [$clog2(DIGITS)-1:0]  digit_idx,
   output logic [DIGITS-1:0]          bad_digit,
   output logic                       frame_done,
   output scan_state_t                state
);

   localparam int IW = $clog2(DIGITS);
   localparam int DW = BCD_W * DIGITS;
   localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL - 1);
   localparam logic [CW-1:0] BLANK_LAST = CW'((BLANK > 0) ? BLANK - 1 : 0);
   localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);

   logic [CW-1:0]     cnt;
   logic [DW-1:0]     disp_buf;
   logic [DW-1:0]     shadow_buf;
   logic              shadow_full;

   logic              dwell_end;
   logic              blank_end;
   logic              start;
   logic              advance;
   logic              wrap;
   logic              swap;
   logic              capture;
   logic [IW-1:0]     load_idx;
   logic [DW-1:0]     next_buf;
   logic [BCD_W-1:0]  sel_digit;
   logic [DEC_W-1:0]  dec_out;
   logic              dec_err;
   logic [DIGITS-1:0] shadow_bad;

   assign wr_ready = ~shadow_full;

   always_comb begin
      dwell_end = (state == S_SHOW)  && (cnt == DWELL_LAST);
      blank_end = (state == S_BLANK) && (cnt == BLANK_LAST);
      start     = enable && (state == S_IDLE);
      // With no blanking gap the end of a dwell moves straight to the next digit.
      advance   = enable && ((dwell_end && (BLANK == 0)) || blank_end);
      wrap      = advance && (digit_idx == IDX_LAST);
      load_idx  = (start || wrap) ? '0 : digit_idx + IW'(1);
      swap      = shadow_full && ((state == S_IDLE) || wrap);
      capture   = wr_valid && !shadow_full;
      // The decoder looks at the digit that will be shown after this edge,
      // taking a same-edge buffer swap into account, so outputs carry no
      // extra latency.
      next_buf  = swap ? shadow_buf : disp_buf;
      sel_digit = next_buf[load_idx*BCD_W +: BCD_W];
   end

   always_comb begin
      shadow_bad = '0;
      for (int i = 0; i < DIGITS; i++) begin
         shadow_bad[i] = bcd_invalid(shadow_buf[i*BCD_W +: BCD_W]);
      end
   end

   bcd_dec10 u_dec (
      .in  (sel_digit),
      .out (dec_out),
      .err (dec_err)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= S_IDLE;
         cnt         <= '0;
         digit_idx   <= '0;
         anode       <= '0;
         cathode     <= '0;
         frame_done  <= 1'b0;
         disp_buf    <= '0;
         shadow_buf  <= '0;
         shadow_full <= 1'b0;
         bad_digit   <= '0;
      end else begin
         frame_done <= wrap;

         // swap needs a full shadow and capture an empty one: never both.
         if (swap) begin
            disp_buf    <= shadow_buf;
            shadow_full <= 1'b0;
            bad_digit   <= shadow_bad;
         end else if (capture) begin
            shadow_buf  <= wr_data;
            shadow_full <= 1'b1;
         end

         if (!enable) begin
            state     <= S_IDLE;
            cnt       <= '0;
            digit_idx <= '0;
            anode     <= '0;
            cathode   <= '0;
         end else if (start || advance) begin
            state     <= S_SHOW;
            cnt       <= '0;
            digit_idx <= load_idx;
            // An invalid code keeps the whole window dark without changing timing.
            anode     <= dec_err ? '0 : DIGITS'(1) << load_idx;
            cathode   <= dec_err ? '0 : dec_out;
         end else if (dwell_end) begin
            state   <= S_BLANK;
            cnt     <= '0;
            anode   <= '0;
            cathode <= '0;
         end else begin
            cnt <= cnt + CW'(1);
         end
      end
   end

endmodule

// File: tb/tb_bcd_scan_ctrl.sv
// Bench for bcd_scan_ctrl: two instances (BLANK=2 and BLANK=0) share the
// same stimulus. A timeline model predicts each cycle's outputs, which are
// queued at drive time and compared once the edge has happened. A table of
// digit patterns checks the displayed numerals digit by digit, and short
// hand-written sequences cover the multi-cycle corner cases.
module tb_bcd_scan_ctrl;
   import bcd_scan_ctrl_pkg::*;

   localparam int ND  = 4;
   localparam int DWL = 4;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic        enable   = 1'b0;
   logic        wr_valid = 1'b0;
   logic [15:0] wr_data  = '0;

   logic        wr_ready_a, fd_a, wr_ready_b, fd_b;
   logic [3:0]  anode_a, bad_a, anode_b, bad_b;
   logic [9:0]  cathode_a, cathode_b;
   logic [1:0]  idx_a, idx_b;
   scan_state_t state_a, state_b;

   bcd_scan_ctrl #(.DIGITS(4), .DWELL(4), .BLANK(2), .CW(16)) u_dut_a (
      .clk(clk), .rst(rst), .enable(enable), .wr_valid(wr_valid),
      .wr_ready(wr_ready_a), .wr_data(wr_data), .anode(anode_a),
      .cathode(cathode_a), .digit_idx(idx_a), .bad_digit(bad_a),
      .frame_done(fd_a), .state(state_a)
   );

   bcd_scan_ctrl #(.DIGITS(4), .DWELL(4), .BLANK(0), .CW(16)) u_dut_b (
      .clk(clk), .rst(rst), .enable(enable), .wr_valid(wr_valid),
      .wr_ready(wr_ready_b), .wr_data(wr_data), .anode(anode_b),
      .cathode(cathode_b), .digit_idx(idx_b), .bad_digit(bad_b),
      .frame_done(fd_b), .state(state_b)
   );

   logic [21:0] act_a, act_b;
   assign act_a = {anode_a, cathode_a, idx_a, bad_a, fd_a, wr_ready_a};
   assign act_b = {anode_b, cathode_b, idx_b, bad_b, fd_b, wr_ready_b};

   // ---------------- timeline model ----------------
   typedef struct packed {
      logic        run;
      logic [7:0]  t;       // cycles since the first SHOW cycle of this frame
      logic [15:0] disp;
      logic [15:0] shadow;
      logic        full;
      logic [3:0]  bad;
      logic        fd;
   } mdl_t;

   mdl_t ma, mb;

   function automatic mdl_t mdl_step(input mdl_t m, input int blank, input logic en,
                                     input logic v, input logic [15:0] d);
      mdl_t n;
      int   period;
      logic sw;
      n      = m;
      n.fd   = 1'b0;
      sw     = 1'b0;
      period = ND * (DWL + blank);
      if (!en) begin
         n.run = 1'b0;
         n.t   = '0;
         sw    = m.full && !m.run;
      end else if (!m.run) begin
         n.run = 1'b1;
         n.t   = '0;
         sw    = m.full;
      end else if (int'(m.t) + 1 == period) begin
         n.t  = '0;
         n.fd = 1'b1;
         sw   = m.full;
      end else begin
         n.t = m.t + 8'd1;
      end
      if (sw) begin
         n.disp = m.shadow;
         n.full = 1'b0;
         for (int i = 0; i < ND; i++) n.bad[i] = (m.shadow[i*4 +: 4] > 4'd9);
      end
      if (v && !m.full) begin
         n.shadow = d;
         n.full   = 1'b1;
      end
      return n;
   endfunction

   function automatic logic [21:0] mdl_out(input mdl_t m, input int blank);
      int         slot, dd, w;
      logic [3:0] dig, an;
      logic [9:0] ca;
      logic [1:0] ix;
      an = '0; ca = '0; ix = '0;
      if (m.run) begin
         slot = DWL + blank;
         dd   = int'(m.t) / slot;
         w    = int'(m.t) % slot;
         ix   = 2'(dd);
         dig  = m.disp[dd*4 +: 4];
         if (w < DWL && dig <= 4'd9) begin
            an = 4'b0001 << dd;
            ca = 10'b1 << dig;
         end
      end
      return {an, ca, ix, m.bad, m.fd, ~m.full};
   endfunction

   // ---------------- scoreboard ----------------
   logic [43:0] exp_q[$];
   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s act=%0h exp=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- driver ----------------
   task automatic step(input logic en, input logic v, input logic [15:0] d);
      logic [43:0] e;
      @(negedge clk);
      enable   = en;
      wr_valid = v;
      wr_data  = d;
      ma = mdl_step(ma, 2, en, v, d);
      mb = mdl_step(mb, 0, en, v, d);
      exp_q.push_back({mdl_out(ma, 2), mdl_out(mb, 0)});
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      check("scan_a", 64'(act_a), 64'(e[43:22]));
      check("scan_b", 64'(act_b), 64'(e[21:0]));
   endtask

   // Steps with enable high until DUT A's model reaches frame time `target`.
   task automatic run_until_t(input int target, input logic need_empty,
                              input logic v, input logic [15:0] d);
      logic ok;
      ok = 1'b0;
      for (int k = 0; k < 200; k++) begin
         if (ma.run && int'(ma.t) == target && (!need_empty || !ma.full)) begin
            ok = 1'b1;
            break;
         end
         step(1'b1, v, d);
      end
      check("wait_budget", 64'(ok), 64'(1));
   endtask

   // ---------------- digit pattern table ----------------
   typedef struct packed {
      logic [15:0] data;
      logic [3:0]  bad;
      logic [15:0] an;   // expected anode per digit, digit i at [4i+3:4i]
      logic [39:0] ca;   // expected cathode per digit, digit i at [10i+9:10i]
   } vec_t;

   vec_t tbl[4];

   initial begin
      int          hits, when_fd, dd;
      logic [3:0]  exp_an;
      logic [9:0]  exp_ca;

      tbl[0] = '{data: 16'hA0F2, bad: 4'b1010, an: {4'b0000, 4'b0100, 4'b0000, 4'b0001},
                 ca: {10'h000, 10'h001, 10'h000, 10'h004}};
      tbl[1] = '{data: 16'h9350, bad: 4'b0000, an: {4'b1000, 4'b0100, 4'b0010, 4'b0001},
                 ca: {10'h200, 10'h008, 10'h020, 10'h001}};
      tbl[2] = '{data: 16'h8761, bad: 4'b0000, an: {4'b1000, 4'b0100, 4'b0010, 4'b0001},
                 ca: {10'h100, 10'h080, 10'h040, 10'h002}};
      tbl[3] = '{data: 16'hBCDE, bad: 4'b1111, an: 16'h0000, ca: 40'h0};

      ma = '0;
      mb = '0;

      // Reset state.
      @(posedge clk);
      @(posedge clk);
      #1;
      check("reset_a", 64'(act_a), 64'(22'h1));
      check("reset_b", 64'(act_b), 64'(22'h1));
      check("reset_state", 64'(state_a), 64'(S_IDLE));
      @(negedge clk);
      rst = 1'b0;

      // Enable with no write: digit 0 shows numeral 0, frame wraps 24 cycles later.
      step(1'b1, 1'b0, '0);
      check("first_anode", 64'(anode_a), 64'(4'b0001));
      check("first_cathode", 64'(cathode_a), 64'(10'h001));
      when_fd = -1;
      for (int k = 1; k <= 30; k++) begin
         step(1'b1, 1'b0, '0);
         if (fd_a && when_fd < 0) when_fd = k;
      end
      check("frame_latency_a", 64'(when_fd), 64'(24));

      // Write during digit 1; applied only at the next frame.
      run_until_t(7, 1'b1, 1'b0, '0);
      step(1'b1, 1'b1, 16'h9350);
      check("busy_after_write", 64'(wr_ready_a), 64'(0));
      check("old_digit_kept", 64'(cathode_a), 64'(10'h001));
      for (int k = 0; k < 48; k++) step(1'b1, 1'b0, '0);
      check("ready_after_swap", 64'(wr_ready_a), 64'(1));

      // Table: write from IDLE, swap, then one displayed frame.
      for (int r = 0; r < 4; r++) begin
         step(1'b0, 1'b0, '0);
         step(1'b0, 1'b0, '0);
         step(1'b0, 1'b1, tbl[r].data);
         step(1'b0, 1'b0, '0);
         check("tbl_bad", 64'(bad_a), 64'(tbl[r].bad));
         step(1'b1, 1'b0, '0);
         for (int k = 1; k < 24; k++) begin
            step(1'b1, 1'b0, '0);
            if (int'(ma.t) % 6 == 2) begin
               dd     = int'(ma.t) / 6;
               exp_an = tbl[r].an[dd*4 +: 4];
               exp_ca = tbl[r].ca[dd*10 +: 10];
               check("tbl_anode", 64'(anode_a), 64'(exp_an));
               check("tbl_cathode", 64'(cathode_a), 64'(exp_ca));
            end
         end
      end

      // Second request while busy is held off until after the swap.
      run_until_t(2, 1'b1, 1'b0, '0);
      step(1'b1, 1'b1, 16'h1234);
      check("busy_second", 64'(wr_ready_a), 64'(0));
      step(1'b1, 1'b1, 16'h5678);
      run_until_t(1, 1'b0, 1'b1, 16'h5678);
      check("first_write_shown", 64'(cathode_a), 64'(10'h010));
      step(1'b1, 1'b0, '0);
      run_until_t(1, 1'b0, 1'b0, '0);
      check("second_write_shown", 64'(cathode_a), 64'(10'h100));

      // Drop enable during digit 2, then restart with a full dwell on digit 0.
      run_until_t(13, 1'b0, 1'b0, '0);
      step(1'b0, 1'b0, '0);
      check("drop_anode", 64'(anode_a), 64'(0));
      check("drop_idx", 64'(idx_a), 64'(0));
      check("drop_state", 64'(state_a), 64'(S_IDLE));
      hits = 0;
      for (int k = 0; k < 5; k++) begin
         step(1'b1, 1'b0, '0);
         if (anode_a == 4'b0001) hits++;
      end
      check("restart_dwell", 64'(hits), 64'(4));

      // Reset during BLANK with a write pending.
      run_until_t(1, 1'b1, 1'b0, '0);
      step(1'b1, 1'b1, 16'h4444);
      run_until_t(4, 1'b0, 1'b0, '0);
      check("pending_before_rst", 64'(wr_ready_a), 64'(0));
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("rst_async_a", 64'(act_a), 64'(22'h1));
      check("rst_async_b", 64'(act_b), 64'(22'h1));
      enable   = 1'b0;
      wr_valid = 1'b0;
      ma = '0;
      mb = '0;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      step(1'b1, 1'b0, '0);
      check("buf_cleared", 64'(cathode_a), 64'(10'h001));
      when_fd = -1;
      for (int k = 1; k <= 20; k++) begin
         step(1'b1, 1'b0, '0);
         if (fd_b && when_fd < 0) when_fd = k;
      end
      check("frame_latency_b", 64'(when_fd), 64'(16));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog act=timeout exp=finish");
      $fatal(1, "watchdog");
   end

endmodule
